// File: rtl/msg_pkg.sv
// Shared definitions for the message streamer.
// Holds the FSM state encoding and the terminator constant, which is the
// all-ones word truncated to whatever ROM width the streamer is built with.
package msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } msg_state_t;

    localparam int unsigned TERM_MAX_W = 64;
    localparam logic [TERM_MAX_W-1:0] TERM_ALL = '1;

endpackage

// File: rtl/message_streamer_if.sv
// Character stream from the message streamer to its sink.
//   out_valid : out_data holds a character
//   out_ready : sink accepts the character this cycle
//   out_data  : character word, attribute bit included
//   out_last  : final character of a non-looping message
interface message_streamer_if #(
    parameter int unsigned DATA_W = 9
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/msg_base_table.sv
// Combinational message start-address lookup.
//   i_msg_sel : message index; indices with no table entry map to entry 0
//   o_base    : start address of the selected message
module msg_base_table #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MSG_COUNT = 4,
    parameter logic [MSG_COUNT*ADDR_W-1:0] MSG_BASE = '0,
    parameter int unsigned SEL_W     = 2
) (
    input  logic [SEL_W-1:0]  i_msg_sel,
    output logic [ADDR_W-1:0] o_base
);

    // Constant-index scan keeps every slice static; unmatched selects fall back to entry 0.
    always_comb begin
        o_base = MSG_BASE[ADDR_W-1:0];
        for (int unsigned i = 0; i < MSG_COUNT; i++) begin
            if (32'(i_msg_sel) == i) begin
                o_base = MSG_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/message_streamer.sv
// Streams terminator-delimited messages out of an external combinational ROM.
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start, msg_sel  : begin streaming the selected message (ignored while busy)
//   loop_en, abort  : repeat at terminator / cancel the stream
//   rom_addr/data   : ROM read port, data returned in the same cycle
//   stream          : valid/ready character output with out_last marker
//   busy, done      : non-idle flag, one-cycle end-of-message pulse
//   char_count      : saturating count of accepted characters since start
module message_streamer
    import msg_pkg::*;
#(
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MSG_COUNT = 4,
    parameter logic [MSG_COUNT*ADDR_W-1:0] MSG_BASE = '0,
    localparam int unsigned SEL_W    = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              loop_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   char_count,
    message_streamer_if.master stream
);

    localparam logic [DATA_W-1:0] TERM = DATA_W'(TERM_ALL);

    msg_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic              r_wrap, w_wrap_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic [ADDR_W:0]   r_count, w_count_nxt;
    logic              r_done, w_done_nxt;
    logic              r_busy, w_busy_nxt;
    logic [ADDR_W-1:0] w_table_base;
    logic [ADDR_W:0]   w_ptr_inc;
    logic              w_term;

    msg_base_table #(
        .ADDR_W    (ADDR_W),
        .MSG_COUNT (MSG_COUNT),
        .MSG_BASE  (MSG_BASE),
        .SEL_W     (SEL_W)
    ) u_base_table (
        .i_msg_sel (msg_sel),
        .o_base    (w_table_base)
    );

    // Carry out of the pointer means the address space ran out; that reads as a terminator.
    assign w_ptr_inc = {1'b0, r_ptr} + (ADDR_W+1)'(1);
    assign w_term    = (rom_data == TERM) || r_wrap;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_base  <= '0;
            r_wrap  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_base  <= w_base_nxt;
            r_wrap  <= w_wrap_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_base_nxt  = r_base;
        w_wrap_nxt  = r_wrap;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_base_nxt  = w_table_base;
                    w_ptr_nxt   = w_table_base;
                    w_wrap_nxt  = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_term) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_data_nxt  = rom_data;
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_ptr_inc[ADDR_W-1:0];
                    w_wrap_nxt  = w_ptr_inc[ADDR_W];
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (stream.out_ready) begin
                    if (r_count != '1) begin
                        w_count_nxt = r_count + (ADDR_W+1)'(1);
                    end
                    if (!w_term) begin
                        // Next word is already on rom_data: load it with no bubble.
                        w_data_nxt = rom_data;
                        w_ptr_nxt  = w_ptr_inc[ADDR_W-1:0];
                        w_wrap_nxt = w_ptr_inc[ADDR_W];
                    end else if (loop_en) begin
                        w_ptr_nxt   = r_base;
                        w_wrap_nxt  = 1'b0;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides any acceptance in the same cycle, so the count is held too.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_count_nxt = r_count;
        end

        w_done_nxt = (w_state_nxt == ST_FINISH);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign rom_addr         = r_ptr;
    assign busy             = r_busy;
    assign done             = r_done;
    assign char_count       = r_count;
    assign stream.out_valid = r_valid;
    assign stream.out_data  = r_data;
    // Looks at the word behind the current character, so it is combinational by nature.
    assign stream.out_last  = (r_state == ST_EMIT) && w_term && !loop_en;

endmodule
